generador_estado_cubos: RTL
===========================

Name: generador_estado_cubos

Overview:
Upstream neighbour of the cube colour selector in Falling Cubes. Tracks the vertical position of 5 falling cubes in fixed columns and advances them once per video frame. For every VGA pixel it emits a registered one-hot `estado_cubos` vector: the bit for the cube covering the pixel, or 0 for background. The colour selector consumes this vector directly. The block also reports when a cube reaches the screen bottom, for the scoring logic.

Parameters:
LADO, 32, cube edge in pixels
COL_BASE, 64, x of cube 0's left edge
COL_PASO, 112, x spacing between cube columns (must be >= LADO)
VEL, 2, pixels fallen per frame tick
ALTO, 480, visible screen height
RETARDO_INI, 4, initial spawn stagger in frames per cube index
SEMILLA, 8'hA5, LFSR reset value (must be non-zero)

Ports:
clk  input  1  pixel clock
reset_n  input  1  asynchronous active-low reset
pixel_x  input  10  current pixel column from VGA sync
pixel_y  input  10  current pixel row from VGA sync
video_on  input  1  high in the visible area
tick_frame  input  1  one-cycle pulse per frame, issued in vertical blanking
inicio  input  1  one-cycle start-game pulse
pausa  input  1  level; freezes cube motion
fin  input  1  one-cycle game-over pulse
estado_cubos  output  5  registered one-hot cube hit for the pixel (bit i = cube i)
cubo_llego  output  5  one-cycle pulse: cube i reached the bottom
jugando  output  1  high while the game state is JUGANDO or PAUSA

Behaviour:
- Reset (async, reset_n=0):
  - game state REPOSO; every cube INACTIVO with Y=0 and counter=0.
  - estado_cubos=0, cubo_llego=0, jugando=0, LFSR=SEMILLA.
- Game FSM:
  - REPOSO: on inicio, go to JUGANDO; cube i enters ESPERA with counter = i*RETARDO_INI.
  - JUGANDO: pausa=1 goes to PAUSA. PAUSA: pausa=0 returns to JUGANDO.
  - fin in JUGANDO or PAUSA: go to REPOSO; all cubes INACTIVO, Y=0.
  - fin takes precedence over inicio, pausa and tick_frame in the same cycle.
  - inicio is ignored outside REPOSO.
- Per-cube FSM: state advances only on tick_frame while in JUGANDO. In PAUSA and REPOSO, ticks are ignored.
  - ESPERA, counter=0 at tick: go to CAYENDO with Y=0.
  - ESPERA, counter>0 at tick: decrement counter.
  - CAYENDO, Y+VEL >= ALTO at tick: go to ESPERA; pulse cubo_llego[i] in the following cycle; counter = {1'b0, LFSR[i+3:i]} + 1 (range 1..16).
  - CAYENDO, otherwise at tick: Y <= Y+VEL. Y is 10 bits, compared unsigned, with no wrap; the exit test above prevents overflow.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clk in every game state. It is never 0.
- Hit detection for cube i:
  - Hit when video_on is high, the cube is CAYENDO, COL_BASE+i*COL_PASO <= pixel_x < COL_BASE+i*COL_PASO+LADO, and Y_i <= pixel_y < Y_i+LADO.
  - Compute the comparison in 11 bits so Y+LADO cannot wrap.
- estado_cubos:
  - Registered; latency exactly 1 clk from pixel_x/pixel_y.
  - If more than one hit is asserted, the lowest index wins, so the output is always one-hot or zero.
  - It stays live in PAUSA (frozen image) and is 0 in REPOSO.
- Positions only change on tick_frame, which occurs during blanking, so a frame never tears.
- cubo_llego: at most one pulse per cube per landing; several bits may be set together.
- Reset mid-frame: outputs clear immediately (async); the next tick_frame after release is ignored because the game is in REPOSO.

Decomposition:
- Shared package/header holds:
  - game-state encodings REPOSO/JUGANDO/PAUSA;
  - cube-state encodings INACTIVO/ESPERA/CAYENDO;
  - screen constants ALTO/ANCHO, shared with the VGA sync and colour selector.
- Natural sub-module: `cubo_caida`, one instance per cube (generate loop). It holds the per-cube FSM, Y, counter and hit compare, and is parameterised by column x.
- The top level holds the game FSM, LFSR, priority encoder and output registers.

Test Plan:
- Reset check: assert reset_n=0 mid-run → estado_cubos=0, cubo_llego=0 and jugando=0 asynchronously. After release, pixel (70,5) gives estado=0.
- Start and first hit: inicio, then 1 tick_frame (cube 0 CAYENDO, Y=0). Pixel (70,10) with video_on → estado_cubos=5'b00001 one clk later. Pixel (96,10) → 0 (right-edge boundary).
- Motion and landing: after inicio, 241 ticks → cubo_llego[0] pulses exactly once, on the cycle after the 241st tick. Cube 0 was at Y=478, so 478+2 >= 480. Cube 0 is in ESPERA and estado bit 0 never asserts.
- Stagger: after inicio and 5 ticks, cube 1 (x=176) is CAYENDO at Y=0. Cube 2 (x=288) is not yet falling: pixel (290,0) → estado=0.
- Pause: freeze at cube 0 Y=20 and apply 10 ticks with pausa=1 → Y stays 20. Pixel (70,20) → 5'b00001; pixel (70,19) → 0.
- Game over priority: fin, inicio and tick_frame in the same cycle → REPOSO, jugando=0, all estado=0, and no cubo_llego pulse.

Source files
------------

// File: rtl/generador_estado_cubos_pkg.sv
// Shared definitions for Falling Cubes: game / cube state encodings, screen
// geometry shared with the VGA sync and colour selector, and the priority
// helper used to keep the cube hit vector one-hot.
package generador_estado_cubos_pkg;

  localparam int ALTO      = 480;  // visible screen height
  localparam int ANCHO     = 640;  // visible screen width
  localparam int NUM_CUBOS = 5;
  localparam int CNT_W     = 5;    // spawn counter, holds 0..16

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    JUGANDO = 2'd1,
    PAUSA   = 2'd2
  } estado_juego_t;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    ESPERA   = 2'd1,
    CAYENDO  = 2'd2
  } estado_cubo_t;

  // Keep only the lowest set bit so overlapping cubes never yield two colours.
  function automatic logic [NUM_CUBOS-1:0] prioridad(input logic [NUM_CUBOS-1:0] v);
    logic [NUM_CUBOS-1:0] r;
    r = '0;
    for (int i = NUM_CUBOS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/generador_estado_cubos_if.sv
// Pixel / control / result bundle between the VGA timing side, the game
// controller and the cube state generator.
//   pixel_x, pixel_y, video_on, tick_frame : from VGA sync
//   inicio, pausa, fin                      : game control
//   estado_cubos, cubo_llego, jugando       : generator results
interface generador_estado_cubos_if;
  import generador_estado_cubos_pkg::*;

  logic [9:0]           pixel_x;
  logic [9:0]           pixel_y;
  logic                 video_on;
  logic                 tick_frame;
  logic                 inicio;
  logic                 pausa;
  logic                 fin;
  logic [NUM_CUBOS-1:0] estado_cubos;
  logic [NUM_CUBOS-1:0] cubo_llego;
  logic                 jugando;

  modport master (
    output pixel_x, pixel_y, video_on, tick_frame, inicio, pausa, fin,
    input  estado_cubos, cubo_llego, jugando
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, tick_frame, inicio, pausa, fin,
    output estado_cubos, cubo_llego, jugando
  );
endinterface

// File: rtl/generador_estado_cubos_cubo_caida.sv
// One falling cube in a fixed column: INACTIVO/ESPERA/CAYENDO state, vertical
// position, spawn counter and the pixel hit compare.
//   clk, reset_n : clock, async active-low reset
//   arrancar     : game start, load spawn stagger cnt_ini
//   borrar       : game over, back to INACTIVO
//   avanzar      : frame tick while playing
//   recarga      : respawn delay loaded on landing (1..16)
//   pixel_x/y, video_on : current pixel
//   hit          : combinational, pixel inside this cube
//   llego        : registered one-cycle landing pulse
module cubo_caida #(
  parameter int X_COL = 64,
  parameter int LADO  = 32,
  parameter int VEL   = 2,
  parameter int ALTO  = 480
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      arrancar,
  input  logic [generador_estado_cubos_pkg::CNT_W-1:0] cnt_ini,
  input  logic                                      borrar,
  input  logic                                      avanzar,
  input  logic [generador_estado_cubos_pkg::CNT_W-1:0] recarga,
  input  logic [9:0]                                pixel_x,
  input  logic [9:0]                                pixel_y,
  input  logic                                      video_on,
  output logic                                      hit,
  output logic                                      llego
);
  import generador_estado_cubos_pkg::*;

  estado_cubo_t     est, est_n;
  logic [9:0]       y, y_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             llego_n;
  logic [10:0]      y_sig;

  // 11-bit sum: the landing test must see Y+VEL without wrapping.
  assign y_sig = {1'b0, y} + 11'(VEL);

  always_comb begin
    est_n   = est;
    y_n     = y;
    cnt_n   = cnt;
    llego_n = 1'b0;
    if (borrar) begin
      est_n = INACTIVO;
      y_n   = '0;
      cnt_n = '0;
    end else if (arrancar) begin
      est_n = ESPERA;
      y_n   = '0;
      cnt_n = cnt_ini;
    end else if (avanzar) begin
      case (est)
        ESPERA: begin
          if (cnt == '0) begin
            est_n = CAYENDO;
            y_n   = '0;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        CAYENDO: begin
          if (y_sig >= 11'(ALTO)) begin
            est_n   = ESPERA;
            cnt_n   = recarga;
            llego_n = 1'b1;
          end else begin
            y_n = y_sig[9:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      est   <= INACTIVO;
      y     <= '0;
      cnt   <= '0;
      llego <= 1'b0;
    end else begin
      est   <= est_n;
      y     <= y_n;
      cnt   <= cnt_n;
      llego <= llego_n;
    end
  end

  logic [10:0] px, py, x_lo, y_lo;
  assign px   = {1'b0, pixel_x};
  assign py   = {1'b0, pixel_y};
  assign x_lo = 11'(X_COL);
  assign y_lo = {1'b0, y};

  assign hit = video_on && (est == CAYENDO) &&
               (px >= x_lo) && (px < x_lo + 11'(LADO)) &&
               (py >= y_lo) && (py < y_lo + 11'(LADO));

endmodule

// File: rtl/generador_estado_cubos.sv
// Falling Cubes cube-state generator. Runs the game FSM, the spawn LFSR and
// one cubo_caida per column, and registers a one-hot per-pixel cube hit for
// the colour selector.
//   clk, reset_n : pixel clock, async active-low reset
//   bus (slave)  : pixel_x/pixel_y/video_on/tick_frame/inicio/pausa/fin in,
//                  estado_cubos/cubo_llego/jugando out
module generador_estado_cubos #(
  parameter int         LADO        = 32,
  parameter int         COL_BASE    = 64,
  parameter int         COL_PASO    = 112,
  parameter int         VEL         = 2,
  parameter int         ALTO        = generador_estado_cubos_pkg::ALTO,
  parameter int         RETARDO_INI = 4,
  parameter logic [7:0] SEMILLA     = 8'hA5
) (
  input logic                      clk,
  input logic                      reset_n,
  generador_estado_cubos_if.slave  bus
);
  import generador_estado_cubos_pkg::*;

  estado_juego_t juego, juego_n;

  always_comb begin
    juego_n = juego;
    case (juego)
      REPOSO:  if (bus.inicio && !bus.fin) juego_n = JUGANDO;
      JUGANDO: if (bus.fin) juego_n = REPOSO;
               else if (bus.pausa) juego_n = PAUSA;
      PAUSA:   if (bus.fin) juego_n = REPOSO;
               else if (!bus.pausa) juego_n = JUGANDO;
      default: juego_n = REPOSO;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) juego <= REPOSO;
    else          juego <= juego_n;
  end

  // fin wins over every other control in the same cycle.
  logic arrancar, borrar, avanzar;
  assign arrancar = (juego == REPOSO) && bus.inicio && !bus.fin;
  assign borrar   = (juego != REPOSO) && bus.fin;
  assign avanzar  = (juego == JUGANDO) && bus.tick_frame && !bus.fin;

  // Fibonacci LFSR x^8+x^6+x^5+x^4, free-running; never reaches 0 from a
  // non-zero seed.
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr <= SEMILLA;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  logic [NUM_CUBOS-1:0] hits, llegos;

  for (genvar i = 0; i < NUM_CUBOS; i++) begin : g_cubo
    logic [CNT_W-1:0] recarga;
    assign recarga = {1'b0, lfsr[i+3:i]} + 5'd1;

    cubo_caida #(
      .X_COL (COL_BASE + i * COL_PASO),
      .LADO  (LADO),
      .VEL   (VEL),
      .ALTO  (ALTO)
    ) u_cubo (
      .clk      (clk),
      .reset_n  (reset_n),
      .arrancar (arrancar),
      .cnt_ini  (CNT_W'(i * RETARDO_INI)),
      .borrar   (borrar),
      .avanzar  (avanzar),
      .recarga  (recarga),
      .pixel_x  (bus.pixel_x),
      .pixel_y  (bus.pixel_y),
      .video_on (bus.video_on),
      .hit      (hits[i]),
      .llego    (llegos[i])
    );
  end

  // Suppress the image on the game-over cycle so the blank starts with fin.
  logic [NUM_CUBOS-1:0] estado_r;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          estado_r <= '0;
    else if (juego != REPOSO && !bus.fin)  estado_r <= prioridad(hits);
    else                                   estado_r <= '0;
  end

  assign bus.estado_cubos = estado_r;
  assign bus.cubo_llego   = llegos;
  assign bus.jugando      = (juego != REPOSO);

endmodule
